// File: rtl/fifo_read_pointer_empty.sv
// Read-domain pointer and status stage of an async FIFO.
// Consumes the synchronized Gray write pointer; produces RAM read address, Gray read pointer and status.
module fifo_read_pointer_empty #(
  parameter int ADDR_SIZE = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk_i,
  input  logic                 r_rst_i,
  input  logic                 r_inc_i,
  input  logic [ADDR_SIZE:0]   r_w_ptr_i,
  input  logic                 r_underflow_clr_i,
  output logic [ADDR_SIZE-1:0] r_addr_o,
  output logic [ADDR_SIZE:0]   r_ptr_o,
  output logic                 r_empty_o,
  output logic                 r_almost_empty_o,
  output logic [ADDR_SIZE:0]   r_level_o,
  output logic                 r_underflow_o
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] wbin;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          underflow_q, underflow_d;
  logic          pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Status flags are computed from the next read pointer, so the last pop flags empty on its own edge.
  always_comb begin
    pop            = r_inc_i & ~empty_q;
    rbin_d         = rbin_q + {{ADDR_SIZE{1'b0}}, pop};
    rgray_d        = (rbin_d >> 1) ^ rbin_d;
    wbin           = gray2bin(r_w_ptr_i);
    level_d        = wbin - rbin_d;
    empty_d        = (rgray_d == r_w_ptr_i);
    almost_empty_d = (level_d <= PW'(AE_THRESH));
    underflow_d    = (r_inc_i & empty_q) | (underflow_q & ~r_underflow_clr_i);
  end

  always_ff @(posedge r_clk_i or posedge r_rst_i) begin
    if (r_rst_i) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      level_q        <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign r_addr_o         = rbin_q[ADDR_SIZE-1:0];
  assign r_ptr_o          = rgray_q;
  assign r_empty_o        = empty_q;
  assign r_almost_empty_o = almost_empty_q;
  assign r_level_o        = level_q;
  assign r_underflow_o    = underflow_q;

endmodule
